// File: rtl/opb_ctrbank_pkg.sv
// Shared constants and types for the OPB counter bank: register map,
// CTRL bit positions and the acknowledge state machine encoding.
package opb_ctrbank_pkg;

  localparam logic [7:0] VERSION   = 8'h01;

  localparam int         OFF_CTRL  = 'h00;
  localparam int         OFF_OVF   = 'h04;
  localparam int         OFF_SNAP0 = 'h08;

  // Bit positions use OPB numbering, where bit 31 is the LSB.
  localparam int         SNAP_BIT  = 31;
  localparam int         CLR_BIT   = 30;

  localparam int         MAX_CH    = 62;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } ack_state_e;

  function automatic logic [31:0] ctrl_word(input int num_ch, input int ctr_width);
    return {VERSION, 8'(num_ch), 8'(ctr_width), 8'h00};
  endfunction

endpackage

// File: rtl/event_counter_ch.sv
// One event counter with a sticky overflow flag and a shadow register that
// captures the live count on a snapshot strobe.
module event_counter_ch #(
  parameter int C_CTR_WIDTH = 32,
  parameter int C_SATURATE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_event,
  input  logic                   i_clr,
  input  logic                   i_snap,
  output logic [C_CTR_WIDTH-1:0] o_shadow,
  output logic                   o_ovf
);

  localparam logic [C_CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [C_CTR_WIDTH-1:0] r_count;
  logic [C_CTR_WIDTH-1:0] r_shadow;
  logic                   r_ovf;

  // NOTE: sequential state uses <= only, so the shadow samples the count as it
  // stood before this edge even though both are updated in the same block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_snap) r_shadow <= r_count;

      if (i_clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (i_event) begin
        if (r_count == CTR_MAX) begin
          r_ovf <= 1'b1;
          if (C_SATURATE == 0) r_count <= '0;
        end else begin
          r_count <= r_count + C_CTR_WIDTH'(1);
        end
      end
    end
  end

  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/opb_counter_bank_simulink2ppc.sv
// OPB slave exposing a bank of event counters: CTRL (snapshot/clear), OVF
// flags and per-channel snapshot words, with a one-cycle ack and a gap cycle.
module opb_counter_bank_simulink2ppc
  import opb_ctrbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01088300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010883FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter int          C_CTR_WIDTH  = 32,
  parameter int          C_SATURATE   = 1,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst_n,
  input  logic [0:31]         OPB_ABus,
  input  logic [0:3]          OPB_BE,
  input  logic [0:31]         OPB_DBus,
  input  logic                OPB_RNW,
  input  logic                OPB_select,
  input  logic                OPB_seqAddr,
  output logic [0:31]         Sl_DBus,
  output logic                Sl_xferAck,
  output logic                Sl_errAck,
  output logic                Sl_retry,
  output logic                Sl_toutSup,
  input  logic [C_NUM_CH-1:0] user_event_in,
  input  logic [C_NUM_CH-1:0] user_clr_in,
  output logic [C_NUM_CH-1:0] ctr_overflow_out
);

  localparam int OVF_BITS = (C_NUM_CH < 32) ? C_NUM_CH : 32;

  logic [31:0] w_offset;
  logic        w_hit;

  assign w_offset = OPB_ABus - C_BASEADDR;
  assign w_hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

  ack_state_e  r_state;
  logic        r_ack;
  logic        r_rnw;
  logic        r_be3;
  logic        r_snap_req;
  logic        r_clr_req;
  logic [29:0] r_word;

  // A hit is accepted in IDLE or GAP but never in ACK, so the cycle after an
  // ack cannot ack again even if the master keeps select high.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_rnw      <= 1'b0;
      r_be3      <= 1'b0;
      r_snap_req <= 1'b0;
      r_clr_req  <= 1'b0;
      r_word     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_hit) begin
            r_state    <= ST_ACK;
            r_ack      <= 1'b1;
            r_rnw      <= OPB_RNW;
            r_be3      <= OPB_BE[3];
            r_snap_req <= OPB_DBus[SNAP_BIT];
            r_clr_req  <= OPB_DBus[CLR_BIT];
            r_word     <= w_offset[31:2];
          end else begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state <= ST_GAP;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  logic w_ctrl_wr;
  logic w_snap;
  logic w_clr_all;

  assign w_ctrl_wr = r_ack && !r_rnw && (r_word == 30'(OFF_CTRL / 4)) && r_be3;
  assign w_snap    = w_ctrl_wr && r_snap_req;
  assign w_clr_all = w_ctrl_wr && r_clr_req;

  logic [C_CTR_WIDTH-1:0] w_shadow [C_NUM_CH];
  logic [C_NUM_CH-1:0]    w_ovf;

  for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
    event_counter_ch #(
      .C_CTR_WIDTH (C_CTR_WIDTH),
      .C_SATURATE  (C_SATURATE)
    ) u_ch (
      .clk      (OPB_Clk),
      .rst_n    (OPB_Rst_n),
      .i_event  (user_event_in[g]),
      .i_clr    (w_clr_all | user_clr_in[g]),
      .i_snap   (w_snap),
      .o_shadow (w_shadow[g]),
      .o_ovf    (w_ovf[g])
    );
  end

  assign ctr_overflow_out = w_ovf;

  logic [31:0] w_rdata;

  // NOTE: w_rdata gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    if (r_word == 30'(OFF_CTRL / 4)) begin
      w_rdata = ctrl_word(C_NUM_CH, C_CTR_WIDTH);
    end else if (r_word == 30'(OFF_OVF / 4)) begin
      w_rdata[OVF_BITS-1:0] = w_ovf[OVF_BITS-1:0];
    end else begin
      for (int k = 0; k < C_NUM_CH; k++) begin
        if (r_word == 30'(OFF_SNAP0 / 4 + k)) w_rdata = 32'(w_shadow[k]);
      end
    end
  end

  assign Sl_DBus    = (r_ack && r_rnw) ? w_rdata : '0;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic w_unused;
  assign w_unused = ^{w_offset[1:0], OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};

endmodule

// File: tb/tb_opb_counter_bank_simulink2ppc.sv
// Bench for opb_counter_bank_simulink2ppc: three instances (32-bit saturating,
// 4-bit saturating, 4-bit wrapping) on one shared bus, checked every cycle.
module tb_opb_counter_bank_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01088300;
  localparam logic [31:0] HIGH = 32'h010883FF;
  localparam int          ND   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seqa;
  logic [3:0]  uev;
  logic [3:0]  uclr;

  logic [0:31] s_dbus  [ND];
  logic        s_ack   [ND];
  logic        s_err   [ND];
  logic        s_retry [ND];
  logic        s_tout  [ND];
  logic [3:0]  s_ovf   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    opb_counter_bank_simulink2ppc #(
      .C_BASEADDR  (BASE),
      .C_HIGHADDR  (HIGH),
      .C_NUM_CH    (4),
      .C_CTR_WIDTH ((g == 0) ? 32 : 4),
      .C_SATURATE  ((g == 2) ? 0 : 1)
    ) u_dut (
      .OPB_Clk          (clk),
      .OPB_Rst_n        (rst_n),
      .OPB_ABus         (abus),
      .OPB_BE           (be),
      .OPB_DBus         (dbus),
      .OPB_RNW          (rnw),
      .OPB_select       (sel),
      .OPB_seqAddr      (seqa),
      .Sl_DBus          (s_dbus[g]),
      .Sl_xferAck       (s_ack[g]),
      .Sl_errAck        (s_err[g]),
      .Sl_retry         (s_retry[g]),
      .Sl_toutSup       (s_tout[g]),
      .user_event_in    (uev),
      .user_clr_in      (uclr),
      .ctr_overflow_out (s_ovf[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: counts, flags and shadows per instance, plus the
  // expected handshake (ack one cycle after an accepted hit, never twice
  // in a row).
  int unsigned     m_cw  [ND] = '{32, 4, 4};
  bit              m_sat [ND] = '{1'b1, 1'b1, 1'b0};
  longint unsigned m_cnt [ND][4];
  longint unsigned m_shd [ND][4];
  bit              m_ovf [ND][4];
  bit              m_ack;
  bit              m_rnw;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [0:3]      m_be;

  bit              md_hit, md_wr, md_snap, md_clr;
  longint unsigned md_max;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < ND; d++)
        for (int i = 0; i < 4; i++) begin
          m_cnt[d][i] = 0; m_shd[d][i] = 0; m_ovf[d][i] = 0;
        end
      m_ack = 0;
    end else begin
      md_hit  = sel && (abus >= BASE) && (abus <= HIGH);
      md_wr   = m_ack && !m_rnw && (((m_addr - BASE) >> 2) == 0) && m_be[3];
      md_snap = md_wr && m_wdata[0];
      md_clr  = md_wr && m_wdata[1];
      for (int d = 0; d < ND; d++) begin
        md_max = (64'd1 << m_cw[d]) - 1;
        for (int i = 0; i < 4; i++) begin
          if (md_snap) m_shd[d][i] = m_cnt[d][i];
          if (md_clr || uclr[i]) begin
            m_cnt[d][i] = 0;
            m_ovf[d][i] = 0;
          end else if (uev[i]) begin
            if (m_cnt[d][i] < md_max) m_cnt[d][i] = m_cnt[d][i] + 1;
            else begin
              m_ovf[d][i] = 1;
              m_cnt[d][i] = m_sat[d] ? md_max : 0;
            end
          end
        end
      end
      if (md_hit && !m_ack) begin
        m_ack = 1; m_rnw = rnw; m_addr = abus; m_wdata = dbus; m_be = be;
      end else begin
        m_ack = 0;
      end
    end
  end

  function automatic logic [3:0] exp_ovf(input int d);
    return {m_ovf[d][3], m_ovf[d][2], m_ovf[d][1], m_ovf[d][0]};
  endfunction

  function automatic logic [31:0] exp_read(input int d, input logic [31:0] addr);
    logic [31:0] word;
    word = (addr - BASE) >> 2;
    if (word == 0) return {8'h01, 8'd4, 8'(m_cw[d]), 8'h00};
    if (word == 1) return {28'd0, exp_ovf(d)};
    if (word >= 2 && word < 6) return 32'(m_shd[d][word - 2]);
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("ack[%0d]", d), s_ack[d], m_ack);
        check($sformatf("dbus[%0d]", d), s_dbus[d],
              (m_ack && m_rnw) ? exp_read(d, m_addr) : 32'd0);
        check($sformatf("ovf_out[%0d]", d), s_ovf[d], exp_ovf(d));
        check($sformatf("tied[%0d]", d), {s_err[d], s_retry[d], s_tout[d]}, 3'b000);
      end
    end
  end

  logic [31:0] rd [ND];
  int          rd_lat;

  task automatic bus_read(input logic [31:0] addr);
    @(posedge clk); #1;
    sel = 1; abus = addr; rnw = 1; be = 4'hF;
    rd_lat = -1;
    for (int d = 0; d < ND; d++) rd[d] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_ack[0]) begin
        rd_lat = k;
        for (int d = 0; d < ND; d++) rd[d] = s_dbus[d];
        break;
      end
    end
    @(posedge clk); #1;
    sel = 0; abus = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] b, input logic [3:0] ev_in_ack);
    @(posedge clk); #1;
    sel = 1; abus = addr; rnw = 0; dbus = wd; be = b;
    @(posedge clk); #1;
    uev = ev_in_ack;
    @(negedge clk);
    check("wr_ack", s_ack[0], 1'b1);
    @(posedge clk); #1;
    sel = 0; uev = '0; dbus = '0; rnw = 1;
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    repeat (n) begin @(posedge clk); #1; uev = m; end
    @(posedge clk); #1; uev = '0;
  endtask

  task automatic read_expect(input string name, input logic [31:0] addr,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] e [ND];
    e = '{e0, e1, e2};
    bus_read(addr);
    check({name, "_lat"}, rd_lat, 1);
    for (int d = 0; d < ND; d++) check($sformatf("%s[%0d]", name, d), rd[d], e[d]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1; sel = 0; rnw = 1; abus = '0; dbus = '0; be = '0; seqa = 0;
    uev = '0; uclr = '0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_ack", s_ack[d], 1'b0);
      check("rst_dbus", s_dbus[d], 32'd0);
      check("rst_ovf", s_ovf[d], 4'h0);
    end

    read_expect("ctrl", BASE, 32'h01042000, 32'h01040400, 32'h01040400);

    pulse(4'b0100, 5);
    bus_write(BASE, 32'h1, 4'hF, 4'h0);
    read_expect("snap2_a", BASE + 'h10, 5, 5, 5);
    pulse(4'b0100, 3);
    read_expect("snap2_b", BASE + 'h10, 5, 5, 5);
    bus_write(BASE, 32'h1, 4'hF, 4'h0);
    read_expect("snap2_c", BASE + 'h10, 8, 8, 8);
    pulse(4'b0100, 1);
    bus_write(BASE, 32'h1, 4'b1110, 4'h0);
    read_expect("snap2_be", BASE + 'h10, 8, 8, 8);
    bus_write(BASE + 'h4, 32'hFFFF_FFFF, 4'hF, 4'h0);

    bus_write(BASE, 32'h2, 4'hF, 4'h0);
    pulse(4'b0001, 20);
    bus_write(BASE, 32'h1, 4'hF, 4'h0);
    read_expect("sat_snap0", BASE + 'h8, 20, 15, 4);
    read_expect("sat_ovf", BASE + 'h4, 0, 1, 1);
    @(negedge clk);
    check("sat_ovf_out[0]", s_ovf[0], 4'h0);
    check("sat_ovf_out[1]", s_ovf[1], 4'h1);
    check("sat_ovf_out[2]", s_ovf[2], 4'h1);

    bus_write(BASE, 32'h2, 4'hF, 4'h0);
    pulse(4'b0010, 7);
    bus_write(BASE, 32'h3, 4'hF, 4'b0010);
    read_expect("snapclr_1", BASE + 'hC, 7, 7, 7);
    bus_write(BASE, 32'h1, 4'hF, 4'h0);
    read_expect("snapclr_2", BASE + 'hC, 0, 0, 0);
    read_expect("snapclr_ovf", BASE + 'h4, 0, 0, 0);

    read_expect("unmapped", BASE + 'h18, 0, 0, 0);
    read_expect("top_word", HIGH - 3, 0, 0, 0);
    bus_read(HIGH + 1);
    check("above_window_noack", rd_lat, -1);
    bus_read(BASE - 4);
    check("below_window_noack", rd_lat, -1);

    pulse(4'b1000, 2);
    @(posedge clk); #1; uev = 4'b1000; uclr = 4'b1000;
    @(posedge clk); #1; uev = '0; uclr = '0;
    bus_write(BASE, 32'h1, 4'hF, 4'h0);
    read_expect("clr_ev_ch3", BASE + 'h14, 0, 0, 0);

    @(posedge clk); #1;
    sel = 1; abus = BASE; rnw = 1; be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold_ack_c%0d", k), s_ack[0], (k == 1) || (k == 3));
      @(posedge clk); #1;
      if (k == 3) sel = 0;
    end

    pulse(4'b0001, 20);
    @(posedge clk); #1;
    sel = 1; abus = BASE; rnw = 1; be = 4'hF;
    #2 rst_n = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rstack_ack", s_ack[d], 1'b0);
      check("rstack_dbus", s_dbus[d], 32'd0);
      check("rstack_ovf", s_ovf[d], 4'h0);
    end
    @(posedge clk); #1;
    sel = 0; rst_n = 1;
    read_expect("post_rst_snap0", BASE + 'h8, 0, 0, 0);
    read_expect("post_rst_ctrl", BASE, 32'h01042000, 32'h01040400, 32'h01040400);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/opb_counter_bank_simulink2ppc.md
Name: opb_counter_bank_simulink2ppc

Overview:
Parametrised bank of C_NUM_CH event counters (e.g. per-port rx overflow counts) with an OPB slave read-out, successor to the single-word user-to-PPC status register. User logic pulses per-channel events. Software takes an atomic snapshot of all counters, reads the snapshot words and sticky overflow flags, and clears the counters over OPB. Everything runs on the single OPB clock; no user clock and no CDC.

Parameters:
C_BASEADDR, 32'h01088300, base of the slave address window
C_HIGHADDR, 32'h010883FF, top of the slave address window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_NUM_CH, 4, channel count, legal range 1..62
C_CTR_WIDTH, 32, counter width, legal range 1..32
C_SATURATE, 1, 1 = counters hold at max; 0 = counters wrap to 0
C_FAMILY, "virtex6", target family string

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst_n  in  1  asynchronous, active-low reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, 0 when not acking
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_event_in  in  [C_NUM_CH-1:0]  one-cycle increment pulse per channel
user_clr_in  in  [C_NUM_CH-1:0]  per-channel synchronous clear
ctr_overflow_out  out  [C_NUM_CH-1:0]  live sticky overflow flags

Behaviour:
- Reset (OPB_Rst_n low, asynchronous):
  - all counters, shadow registers and overflow flags go to 0
  - Sl_xferAck = 0, Sl_DBus = 0
  - reset mid-transfer aborts the transfer; no ack is issued afterwards.
- Address map (byte offsets from C_BASEADDR):
  - 0x00 CTRL
  - 0x04 OVF
  - 0x08 + 4*i SNAP[i]
  - A hit is OPB_select=1 with C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Handshake:
  - A hit in cycle N produces Sl_xferAck=1 in cycle N+1, for exactly one cycle.
  - The cycle after an ack never acks, even if select is still high. Back-to-back transfers therefore ack at most every 2 cycles.
  - A write takes effect in the ack cycle.
  - For a read, Sl_DBus carries data only during the ack cycle.
- Bit numbering: OPB bit 31 is the LSB. Narrow values are zero-extended into the LSBs.
- CTRL read returns version 8'h01 in bits [0:7], C_NUM_CH in [8:15], C_CTR_WIDTH in [16:23], and 0 in [24:31].
- CTRL write is honoured only if OPB_BE[3]=1:
  - DBus[31] = snapshot: every SNAP[i] takes the counter's value registered at the start of the ack cycle, i.e. excluding that cycle's event.
  - DBus[30] = clear-all: all counters and overflow flags become 0 at the end of the ack cycle. Events in that cycle are lost.
  - Both bits set: the snapshot captures the pre-clear values.
- OVF read returns the overflow flags in the LSBs. Writes to OVF are ignored.
- SNAP[i] reads return the shadow value. Offsets past the last channel within the window read 0. Writes to SNAP or unmapped offsets are acked and ignored.
- Per-channel counter priority: clear-all or user_clr_in[i], then event.
  - A clear in the same cycle as an event gives 0; the flag is also cleared.
  - Event below max: +1.
  - Event at max (2^C_CTR_WIDTH - 1) with C_SATURATE=1: hold the value, set the flag.
  - Event at max with C_SATURATE=0: go to 0, set the flag.
  - The flag is sticky until cleared.
- ctr_overflow_out is registered; it equals the OVF contents.

Decomposition:
- Shared package opb_ctrbank_pkg holds:
  - offset constants CTRL/OVF/SNAP0
  - the VERSION constant
  - CTRL bit indices SNAP_BIT=31 and CLR_BIT=30
  - a max-channel limit constant (62).
- Sub-module event_counter_ch: one counter plus its overflow flag, with C_CTR_WIDTH/C_SATURATE parameters and inputs event, clr, snap. It holds the shadow register, and the top level instantiates it C_NUM_CH times.
- The top level contains the OPB decode, the ack FSM (IDLE -> ACK -> GAP -> IDLE) and the read mux.

Test Plan:
- Reset, then read CTRL at 0x01088300 -> ack exactly 1 cycle after select; data 32'h01042000 for default parameters.
- 5 pulses on ch2, write CTRL=0x1, read 0x01088310 -> 5; a further 3 events do not change the read value until the next snapshot.
- C_CTR_WIDTH=4, C_SATURATE=1: 20 events on ch0, snapshot -> SNAP0=15, OVF=0x1, ctr_overflow_out[0]=1.
- Same with C_SATURATE=0 -> SNAP0=4, OVF=0x1.
- Write CTRL=0x3 while ch1 holds 7 and an event pulses in the ack cycle -> SNAP1=7; after a fresh snapshot, SNAP1=0 and OVF=0.
- user_clr_in[3] and user_event_in[3] in the same cycle -> ch3=0. Select held high for 4 cycles -> acks in cycles 1 and 3 only. Assert OPB_Rst_n low during a pending ack -> no ack; Sl_DBus=0.
